// File: rtl/maxpool2x2_ctrl_pkg.sv
// Package pool_pkg: FSM state encoding, default widths, and the frame-size legality helper.
// Shared by the controller, its bus interface and the testbench.
package pool_pkg;

    localparam int DATA_WIDTH_DEF = 32;
    localparam int DIM_W_DEF      = 8;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_EVEN_ROW = 3'd1,
        ST_ODD_ROW  = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_DONE     = 3'd4
    } pool_state_e;

    // A frame is poolable only if it tiles exactly into 2x2 windows and fits the line buffer.
    function automatic logic dims_legal(input int w, input int h, input int max_w);
        dims_legal = (w[0] == 1'b0) && (h[0] == 1'b0) && (w >= 2) && (h >= 2) && (w <= max_w);
    endfunction

endpackage

// File: rtl/maxpool2x2_ctrl_if.sv
// Pixel stream and max-pool unit handshake bundle for maxpool2x2_ctrl.
// master = the controller side, slave = pixel source / pool-unit side.
interface maxpool2x2_ctrl_if #(
    parameter int DATA_WIDTH = pool_pkg::DATA_WIDTH_DEF
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] pool_a;
    logic [DATA_WIDTH-1:0] pool_b;
    logic [DATA_WIDTH-1:0] pool_c;
    logic [DATA_WIDTH-1:0] pool_d;
    logic                  pool_valid;
    logic                  pool_valid_out;

    modport master (
        input  in_data, in_valid, pool_valid_out,
        output in_ready, pool_a, pool_b, pool_c, pool_d, pool_valid
    );

    modport slave (
        output in_data, in_valid, pool_valid_out,
        input  in_ready, pool_a, pool_b, pool_c, pool_d, pool_valid
    );

endinterface

// File: rtl/maxpool2x2_ctrl_line_buf.sv
// pool_line_buf: one-row pixel store, one write port, one combinational read port.
// Contents are deliberately not reset; every frame rewrites a row before reading it.
module pool_line_buf #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_W      = 224,
    parameter int ADDR_W     = 8
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem_r [0:MAX_W-1];

    // Store the even-row pixel at its column slot
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/maxpool2x2_ctrl.sv
// maxpool2x2_ctrl: sequences a raster pixel stream into 2x2 windows for an external max-pool unit.
// Even rows are parked in the line buffer; odd rows pair with them to form windows.
// Optional build macro MAXPOOL_CTRL_STATS_EN adds a saturating stall_cnt output.
module maxpool2x2_ctrl
    import pool_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int MAX_W      = 224,
    parameter int DIM_W      = DIM_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DIM_W-1:0] cfg_width,
    input  logic [DIM_W-1:0] cfg_height,
    maxpool2x2_ctrl_if.master bus,
    output logic             busy,
    output logic             done,
    output logic             cfg_err
`ifdef MAXPOOL_CTRL_STATS_EN
    ,
    output logic [31:0]      stall_cnt
`endif
);

    localparam int LB_AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam int RES_W = 2 * DIM_W;

    pool_state_e state_r;
    pool_state_e state_nxt_s;

    logic [DIM_W-1:0]      width_r;
    logic [DIM_W-1:0]      height_r;
    logic [DIM_W-1:0]      col_r;
    logic [DIM_W-1:0]      row_r;
    logic [RES_W-1:0]      res_cnt_r;
    logic [RES_W-1:0]      res_total_r;
    logic [DATA_WIDTH-1:0] held_r;
    logic [DATA_WIDTH-1:0] lb_hold_r;
    logic [DATA_WIDTH-1:0] pool_a_r;
    logic [DATA_WIDTH-1:0] pool_b_r;
    logic [DATA_WIDTH-1:0] pool_c_r;
    logic [DATA_WIDTH-1:0] pool_d_r;
    logic                  pool_valid_r;
    logic                  in_ready_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  cfg_err_r;

    logic                  in_ready_nxt_s;
    logic                  busy_nxt_s;
    logic                  done_nxt_s;
    logic                  legal_s;
    logic                  start_ok_s;
    logic                  start_bad_s;
    logic                  accept_s;
    logic                  col_last_s;
    logic                  row_last_s;
    logic                  lb_wr_en_s;
    logic [LB_AW-1:0]      lb_addr_s;
    logic [DATA_WIDTH-1:0] lb_rd_data_s;

    assign legal_s     = dims_legal(int'(cfg_width), int'(cfg_height), MAX_W);
    assign start_ok_s  = start && (state_r == ST_IDLE) && legal_s;
    assign start_bad_s = start && (state_r == ST_IDLE) && !legal_s;
    assign accept_s    = bus.in_valid && in_ready_r;
    assign col_last_s  = (col_r == (width_r - DIM_W'(1)));
    assign row_last_s  = (row_r == (height_r - DIM_W'(1)));

    // The write column and the read column are always the current column
    assign lb_wr_en_s = accept_s && (state_r == ST_EVEN_ROW);
    assign lb_addr_s  = LB_AW'(col_r);

    pool_line_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_W      (MAX_W),
        .ADDR_W     (LB_AW)
    ) u_line_buf (
        .clk     (clk),
        .wr_en   (lb_wr_en_s),
        .wr_addr (lb_addr_s),
        .wr_data (bus.in_data),
        .rd_addr (lb_addr_s),
        .rd_data (lb_rd_data_s)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode: rows advance only on an accepted last-column pixel
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) state_nxt_s = ST_EVEN_ROW;
                else            state_nxt_s = ST_IDLE;
            end
            ST_EVEN_ROW: begin
                if (accept_s && col_last_s) state_nxt_s = ST_ODD_ROW;
                else                        state_nxt_s = ST_EVEN_ROW;
            end
            ST_ODD_ROW: begin
                if (accept_s && col_last_s) begin
                    if (row_last_s) state_nxt_s = ST_DRAIN;
                    else            state_nxt_s = ST_EVEN_ROW;
                end else begin
                    state_nxt_s = ST_ODD_ROW;
                end
            end
            ST_DRAIN: begin
                if (res_cnt_r == res_total_r) state_nxt_s = ST_DONE;
                else                          state_nxt_s = ST_DRAIN;
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it
    always_comb begin
        in_ready_nxt_s = 1'b0;
        busy_nxt_s     = 1'b0;
        done_nxt_s     = 1'b0;
        case (state_nxt_s)
            ST_EVEN_ROW, ST_ODD_ROW: begin
                in_ready_nxt_s = 1'b1;
                busy_nxt_s     = 1'b1;
            end
            ST_DRAIN: begin
                busy_nxt_s = 1'b1;
            end
            ST_DONE: begin
                busy_nxt_s = 1'b1;
                done_nxt_s = 1'b1;
            end
            default: begin
                in_ready_nxt_s = 1'b0;
                busy_nxt_s     = 1'b0;
                done_nxt_s     = 1'b0;
            end
        endcase
    end

    // Registered control outputs; cfg_err only clears through reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            cfg_err_r  <= 1'b0;
        end else begin
            in_ready_r <= in_ready_nxt_s;
            busy_r     <= busy_nxt_s;
            done_r     <= done_nxt_s;
            if (start_bad_s) cfg_err_r <= 1'b1;
            else             cfg_err_r <= cfg_err_r;
        end
    end

    // Frame geometry latch and column/row position; a stall leaves everything put
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width_r     <= '0;
            height_r    <= '0;
            col_r       <= '0;
            row_r       <= '0;
            res_total_r <= '0;
        end else if (start_ok_s) begin
            width_r     <= cfg_width;
            height_r    <= cfg_height;
            col_r       <= '0;
            row_r       <= '0;
            res_total_r <= RES_W'(cfg_width[DIM_W-1:1]) * RES_W'(cfg_height[DIM_W-1:1]);
        end else if (accept_s) begin
            if (col_last_s) begin
                col_r <= '0;
                if (row_last_s) row_r <= '0;
                else            row_r <= row_r + DIM_W'(1);
            end else begin
                col_r <= col_r + DIM_W'(1);
            end
        end
    end

    // Count results returned by the pool unit, including one landing on the DRAIN entry edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_cnt_r <= '0;
        end else if (start_ok_s) begin
            res_cnt_r <= '0;
        end else if (bus.pool_valid_out && (state_r != ST_IDLE)) begin
            res_cnt_r <= res_cnt_r + RES_W'(1);
        end else begin
            res_cnt_r <= res_cnt_r;
        end
    end

    // Even column of an odd row parks both top-left and bottom-left; odd column fires the window
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_r       <= '0;
            lb_hold_r    <= '0;
            pool_a_r     <= '0;
            pool_b_r     <= '0;
            pool_c_r     <= '0;
            pool_d_r     <= '0;
            pool_valid_r <= 1'b0;
        end else if (accept_s && (state_r == ST_ODD_ROW)) begin
            if (col_r[0] == 1'b0) begin
                held_r       <= bus.in_data;
                lb_hold_r    <= lb_rd_data_s;
                pool_valid_r <= 1'b0;
            end else begin
                pool_a_r     <= lb_hold_r;
                pool_b_r     <= lb_rd_data_s;
                pool_c_r     <= held_r;
                pool_d_r     <= bus.in_data;
                pool_valid_r <= 1'b1;
            end
        end else begin
            pool_valid_r <= 1'b0;
        end
    end

`ifdef MAXPOOL_CTRL_STATS_EN
    logic [31:0] stall_cnt_r;

    // Saturating count of input-starved cycles while rows are being accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_r <= 32'd0;
        end else if (start_ok_s) begin
            stall_cnt_r <= 32'd0;
        end else if (((state_r == ST_EVEN_ROW) || (state_r == ST_ODD_ROW)) &&
                     !bus.in_valid && (stall_cnt_r != 32'hFFFF_FFFF)) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign stall_cnt = stall_cnt_r;
`endif

    assign bus.in_ready   = in_ready_r;
    assign bus.pool_a     = pool_a_r;
    assign bus.pool_b     = pool_b_r;
    assign bus.pool_c     = pool_c_r;
    assign bus.pool_d     = pool_d_r;
    assign bus.pool_valid = pool_valid_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign cfg_err        = cfg_err_r;

endmodule

// File: tb/tb_maxpool2x2_ctrl.sv
// Directed testbench for maxpool2x2_ctrl with a 1-cycle max-pool unit model attached.
// Honours MAXPOOL_CTRL_STATS_EN for the stall_cnt checks.
`timescale 1ns/1ps
module tb_maxpool2x2_ctrl;

    localparam int DW   = 32;
    localparam int MW   = 224;
    localparam int DIMW = 8;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [DIMW-1:0] cfg_width = '0;
    logic [DIMW-1:0] cfg_height = '0;
    logic            busy;
    logic            done;
    logic            cfg_err;
`ifdef MAXPOOL_CTRL_STATS_EN
    logic [31:0]     stall_cnt;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    maxpool2x2_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    maxpool2x2_ctrl #(
        .DATA_WIDTH (DW),
        .MAX_W      (MW),
        .DIM_W      (DIMW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_width  (cfg_width),
        .cfg_height (cfg_height),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .cfg_err    (cfg_err)
`ifdef MAXPOOL_CTRL_STATS_EN
        ,
        .stall_cnt  (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // External max-pool unit: result one cycle after the window
    logic [DW-1:0] pool_res;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pool_valid_out <= 1'b0;
            pool_res           <= '0;
        end else begin
            bus.pool_valid_out <= bus.pool_valid;
            pool_res <= max4(bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d);
        end
    end

    function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
        logic [DW-1:0] m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    // Window k of a frame whose pixel (r,c) holds base + r*w + c
    function automatic logic [4*DW-1:0] exp_win(input int base, input int w, input int k);
        int r;
        int c;
        r = 2 * (k / (w / 2));
        c = 2 * (k % (w / 2));
        return {DW'(base + r*w + c), DW'(base + r*w + c + 1),
                DW'(base + (r+1)*w + c), DW'(base + (r+1)*w + c + 1)};
    endfunction

    // Monitor: collect windows, results, done pulses and back-to-back pool_valid
    int cyc = 0;
    logic [4*DW-1:0] win_q [$];
    logic [DW-1:0]   res_q [$];
    int done_cnt = 0;
    int done_cyc = 0;
    int last_pv_cyc = 0;
    int dup_cnt = 0;
    int res_at_done = 0;
    logic prev_pv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.pool_valid) begin
            win_q.push_back({bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d});
            last_pv_cyc <= cyc;
        end
        if (bus.pool_valid && prev_pv) dup_cnt <= dup_cnt + 1;
        prev_pv <= bus.pool_valid;
        if (bus.pool_valid_out) res_q.push_back(pool_res);
        if (done) begin
            done_cnt    <= done_cnt + 1;
            done_cyc    <= cyc;
            res_at_done <= res_q.size();
        end
    end

    task automatic do_start(input int w, input int h);
        @(negedge clk);
        cfg_width  = DIMW'(w);
        cfg_height = DIMW'(h);
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    // Feed n pixels base, base+1, ...; optional alternate-cycle valid and a stray mid-frame start
    task automatic feed(input int base, input int n, input bit toggle, input int mid_start_at);
        int i = 0;
        int guard = 0;
        bit phase = 1'b0;
        bit v;
        bit started = 1'b0;
        while (i < n && guard < 4*n + 20) begin
            v = toggle ? ~phase : 1'b1;
            phase = ~phase;
            bus.in_valid = v;
            bus.in_data  = DW'(base + i);
            if (i == mid_start_at && !started) begin
                start = 1'b1; cfg_width = 8'd2; cfg_height = 8'd2; started = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (v && bus.in_ready) i++;
            @(negedge clk);
            guard++;
        end
        bus.in_valid = 1'b0;
        start = 1'b0;
        n_cmp++;
        if (i != n) begin
            n_fail++;
            $display("FAIL feed_timeout: accepted %0d want %0d", i, n);
        end
    endtask

    task automatic wait_done(input int d0, input int bound);
        int k = 0;
        while (done_cnt == d0 && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        n_cmp++;
        if (done_cnt == d0) begin
            n_fail++;
            $display("FAIL done_timeout: done_cnt %0d after %0d cycles", done_cnt, k);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", bus.in_ready); end
        n_cmp++; if (bus.pool_valid !== 1'b0) begin n_fail++; $display("FAIL rst_pool_valid: got %b want 0", bus.pool_valid); end
        n_cmp++; if ({bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d} !== '0)
                 begin n_fail++; $display("FAIL rst_pool_ops: got %h want 0", {bus.pool_a, bus.pool_b, bus.pool_c, bus.pool_d}); end
        n_cmp++; if ({busy, done, cfg_err} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {busy, done, cfg_err}); end
        rst_n = 1'b1;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (bus.in_ready !== 1'b0 || win_q.size() != 0)
                 begin n_fail++; $display("FAIL no_start_accept: in_ready %b windows %0d want 0 0", bus.in_ready, win_q.size()); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_frame_4x4();
        logic [4*DW-1:0] ew [4];
        logic [DW-1:0]   er [4];
        int d0;
        ew[0] = {32'd0, 32'd1, 32'd4, 32'd5};
        ew[1] = {32'd2, 32'd3, 32'd6, 32'd7};
        ew[2] = {32'd8, 32'd9, 32'd12, 32'd13};
        ew[3] = {32'd10, 32'd11, 32'd14, 32'd15};
        er[0] = 32'd5; er[1] = 32'd7; er[2] = 32'd13; er[3] = 32'd15;
        win_q.delete(); res_q.delete();
        d0 = done_cnt;
        do_start(4, 4);
        n_cmp++; if (busy !== 1'b1 || bus.in_ready !== 1'b1)
                 begin n_fail++; $display("FAIL f4_busy_ready: got %b%b want 11", busy, bus.in_ready); end
        feed(0, 16, 1'b0, -1);
        wait_done(d0, 50);
        n_cmp++; if (win_q.size() != 4) begin n_fail++; $display("FAIL f4_win_count: got %0d want 4", win_q.size()); end
        for (int k = 0; k < 4 && k < win_q.size(); k++) begin
            n_cmp++; if (win_q[k] !== ew[k]) begin n_fail++; $display("FAIL f4_win%0d: got %h want %h", k, win_q[k], ew[k]); end
        end
        for (int k = 0; k < 4 && k < res_q.size(); k++) begin
            n_cmp++; if (res_q[k] !== er[k]) begin n_fail++; $display("FAIL f4_res%0d: got %0d want %0d", k, res_q[k], er[k]); end
        end
        n_cmp++; if (done_cyc - last_pv_cyc != 3) begin n_fail++; $display("FAIL f4_done_lat: got %0d want 3", done_cyc - last_pv_cyc); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL f4_done_cnt: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (dup_cnt != 0) begin n_fail++; $display("FAIL f4_dup_pv: got %0d want 0", dup_cnt); end
        n_cmp++; if (bus.pool_valid !== 1'b0 || bus.pool_a !== 32'd10 || bus.pool_d !== 32'd15)
                 begin n_fail++; $display("FAIL f4_hold: got pv %b a %0d d %0d want 0 10 15", bus.pool_valid, bus.pool_a, bus.pool_d); end
        n_cmp++; if (busy !== 1'b0 || bus.in_ready !== 1'b0)
                 begin n_fail++; $display("FAIL f4_idle: got busy %b ready %b want 0 0", busy, bus.in_ready); end
    endtask

    task automatic test_stall_4x2();
        int d0;
        win_q.delete(); res_q.delete();
        d0 = done_cnt;
        do_start(4, 2);
        feed(0, 8, 1'b1, -1);
        wait_done(d0, 50);
        n_cmp++; if (win_q.size() != 2) begin n_fail++; $display("FAIL st_win_count: got %0d want 2", win_q.size()); end
        for (int k = 0; k < 2 && k < win_q.size(); k++) begin
            n_cmp++; if (win_q[k] !== exp_win(0, 4, k)) begin n_fail++; $display("FAIL st_win%0d: got %h want %h", k, win_q[k], exp_win(0, 4, k)); end
        end
        n_cmp++; if (dup_cnt != 0) begin n_fail++; $display("FAIL st_dup_pv: got %0d want 0", dup_cnt); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL st_done_cnt: got %0d want 1", done_cnt - d0); end
`ifdef MAXPOOL_CTRL_STATS_EN
        n_cmp++; if (stall_cnt !== 32'd7) begin n_fail++; $display("FAIL st_stall_cnt: got %0d want 7", stall_cnt); end
`endif
    endtask

    task automatic test_mid_start();
        int d0;
        win_q.delete(); res_q.delete();
        d0 = done_cnt;
        do_start(4, 4);
        feed(50, 16, 1'b0, 6);
        wait_done(d0, 50);
        repeat (20) @(negedge clk);
        n_cmp++; if (win_q.size() != 4) begin n_fail++; $display("FAIL ms_win_count: got %0d want 4", win_q.size()); end
        for (int k = 0; k < 4 && k < win_q.size(); k++) begin
            n_cmp++; if (win_q[k] !== exp_win(50, 4, k)) begin n_fail++; $display("FAIL ms_win%0d: got %h want %h", k, win_q[k], exp_win(50, 4, k)); end
        end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL ms_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_wide_224x2();
        int d0;
        int bad = 0;
        win_q.delete(); res_q.delete();
        d0 = done_cnt;
        do_start(224, 2);
        feed(1000, 448, 1'b0, -1);
        wait_done(d0, 100);
        n_cmp++; if (win_q.size() != 112) begin n_fail++; $display("FAIL w_win_count: got %0d want 112", win_q.size()); end
        for (int k = 0; k < 112 && k < win_q.size(); k++) begin
            if (win_q[k] !== exp_win(1000, 224, k)) bad++;
        end
        n_cmp++; if (bad != 0) begin n_fail++; $display("FAIL w_windows: got %0d wrong windows want 0", bad); end
        n_cmp++; if (win_q.size() > 111 && win_q[111] !== exp_win(1000, 224, 111))
                 begin n_fail++; $display("FAIL w_last_win: got %h want %h", win_q[111], exp_win(1000, 224, 111)); end
        n_cmp++; if (res_at_done != 112) begin n_fail++; $display("FAIL w_res_before_done: got %0d want 112", res_at_done); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL w_done_cnt: got %0d want 1", done_cnt - d0); end
        n_cmp++; if (dup_cnt != 0) begin n_fail++; $display("FAIL w_dup_pv: got %0d want 0", dup_cnt); end
    endtask

    task automatic test_cfg_err();
        win_q.delete();
        do_start(5, 4);
        bus.in_valid = 1'b1;
        repeat (4) @(negedge clk);
        n_cmp++; if (cfg_err !== 1'b1) begin n_fail++; $display("FAIL ce_flag: got %b want 1", cfg_err); end
        n_cmp++; if (bus.in_ready !== 1'b0 || busy !== 1'b0)
                 begin n_fail++; $display("FAIL ce_idle: got ready %b busy %b want 0 0", bus.in_ready, busy); end
        n_cmp++; if (win_q.size() != 0) begin n_fail++; $display("FAIL ce_windows: got %0d want 0", win_q.size()); end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        int d0;
        win_q.delete(); res_q.delete();
        d0 = done_cnt;
        do_start(4, 4);
        feed(0, 5, 1'b0, -1);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if ({busy, bus.in_ready, cfg_err} !== 3'b000)
                 begin n_fail++; $display("FAIL rm_flags: got %b want 000", {busy, bus.in_ready, cfg_err}); end
        rst_n = 1'b1;
        @(negedge clk);
        do_start(2, 2);
        feed(100, 4, 1'b0, -1);
        wait_done(d0, 50);
        n_cmp++; if (win_q.size() != 1) begin n_fail++; $display("FAIL rm_win_count: got %0d want 1", win_q.size()); end
        n_cmp++; if (win_q.size() > 0 && win_q[0] !== {32'd100, 32'd101, 32'd102, 32'd103})
                 begin n_fail++; $display("FAIL rm_win: got %h want 100,101,102,103", win_q[0]); end
        n_cmp++; if (done_cnt - d0 != 1) begin n_fail++; $display("FAIL rm_done_cnt: got %0d want 1", done_cnt - d0); end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        test_reset();
        test_frame_4x4();
        test_stall_4x2();
        test_mid_start();
        test_wide_224x2();
        test_cfg_err();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
